// File: rtl/mesi_snoop_cache.sv
// mesi_snoop_cache: direct-mapped write-back MESI cache with bus snooping and a req/ack memory port.
// Define MESI_STATS_EN to add saturating hit/miss/write-back counters.
module mesi_snoop_cache #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              awvalid,
  input  logic              wvalid,
  input  logic              arvalid,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              w_hit,
  output logic              r_hit,
  output logic [1:0]        w_resp,
  output logic [1:0]        r_resp,
  output logic              bus_req,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  input  logic              bus_shared,
  input  logic              snp_valid,
  input  logic [1:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              snp_shared,
  output logic              snp_flush,
  output logic [DATA_W-1:0] snp_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
`ifdef MESI_STATS_EN
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       wb_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int TAG_W = ADDR_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;
  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, UPGR, WB, BUS, FILL} fsm_e;
  fsm_e fsm_q, fsm_d;
  logic [LINES-1:0][1:0] st_q, st_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d, snp_data_q, data_wv;
  logic wr_q, wr_d, shared_q, shared_d, w_hit_q, w_hit_d, r_hit_q, r_hit_d, snp_flush_q;
  logic [1:0] w_resp_q, w_resp_d, r_resp_q, r_resp_d, line_st, snp_st, snp_nx;
  logic [INDEX_W-1:0] idx, sidx;
  logic [TAG_W-1:0] tag, stag;
  logic [ADDR_W-1:0] line_addr;
  logic hit, req_err, fill_done, flush_now, data_we, tag_we, snp_unused;
  assign idx        = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[ADDR_W-3:INDEX_W];
  assign line_addr  = {addr_q, 2'b00};
  assign line_st    = st_q[idx];
  assign hit        = line_st != ST_I && tag_q[idx] == tag;
  assign sidx       = snp_addr[INDEX_W+1:2];
  assign stag       = snp_addr[ADDR_W-1:INDEX_W+2];
  assign snp_unused = ^snp_addr[1:0];
  assign snp_st     = st_q[sidx];
  assign snp_shared = snp_valid && snp_st != ST_I && tag_q[sidx] == stag;
  // E and M both have bit 1 set, so a BusRd demotes either to S
  assign snp_nx     = snp_op == 2'b10 ? ST_I :
                      snp_op == 2'b01 && snp_st[1] ? ST_S :
                      snp_op == 2'b11 && snp_st == ST_S ? ST_I : snp_st;
  assign flush_now  = snp_shared && snp_st == ST_M && (snp_op == 2'b01 || snp_op == 2'b10);
  assign req_err    = (awvalid && !wvalid) || (awvalid && arvalid) || data_addr[1:0] != 2'b00;
  assign fill_done  = fsm_q == FILL && mem_ack;
  assign rvalid     = r_resp_q == 2'b01;
  assign rdata      = rdata_q;
  assign w_hit      = w_hit_q;
  assign r_hit      = r_hit_q;
  assign w_resp     = w_resp_q;
  assign r_resp     = r_resp_q;
  assign snp_flush  = snp_flush_q;
  assign snp_data   = snp_data_q;
  always_comb begin
    fsm_d = fsm_q;
    st_d = st_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    shared_d = shared_q;
    rdata_d = rdata_q;
    w_resp_d = w_resp_q;
    r_resp_d = r_resp_q;
    w_hit_d = w_hit_q;
    r_hit_d = r_hit_q;
    data_we = 1'b0;
    tag_we = 1'b0;
    data_wv = wdata_q;
    bus_req = 1'b0;
    bus_op = 2'b00;
    bus_addr = '0;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (fsm_q)
      IDLE: if (awvalid || arvalid) begin
        w_resp_d = req_err && awvalid ? 2'b11 : 2'b00;
        r_resp_d = req_err && arvalid ? 2'b11 : 2'b00;
        w_hit_d = 1'b0;
        r_hit_d = 1'b0;
        rdata_d = '0;
        addr_d = data_addr[ADDR_W-1:2];
        wdata_d = wdata;
        wr_d = awvalid;
        fsm_d = req_err ? IDLE : LOOKUP;
      end
      LOOKUP: if (!hit) fsm_d = line_st == ST_M ? WB : BUS;
      else if (!wr_q) begin
        r_resp_d = 2'b01;
        r_hit_d = 1'b1;
        rdata_d = data_q[idx];
        fsm_d = RESP;
      end else if (line_st == ST_S) fsm_d = UPGR;
      else begin
        data_we = 1'b1;
        st_d[idx] = ST_M;
        w_resp_d = 2'b01;
        w_hit_d = 1'b1;
        fsm_d = RESP;
      end
      // a peer invalidated our S copy while waiting: fetch it exclusively instead
      UPGR: if (line_st != ST_S) fsm_d = BUS;
      else begin
        bus_req = 1'b1;
        bus_op = 2'b11;
        bus_addr = line_addr;
        if (bus_gnt) begin
          data_we = 1'b1;
          st_d[idx] = ST_M;
          w_resp_d = 2'b01;
          w_hit_d = 1'b1;
          fsm_d = RESP;
        end
      end
      WB: begin
        mem_req = 1'b1;
        mem_we = 1'b1;
        mem_addr = {tag_q[idx], idx, 2'b00};
        mem_wdata = data_q[idx];
        if (mem_ack) begin
          st_d[idx] = ST_I;
          fsm_d = BUS;
        end
      end
      BUS: begin
        bus_req = 1'b1;
        bus_op = wr_q ? 2'b10 : 2'b01;
        bus_addr = line_addr;
        if (bus_gnt) begin
          shared_d = bus_shared;
          fsm_d = FILL;
        end
      end
      FILL: begin
        mem_req = 1'b1;
        mem_addr = line_addr;
        if (mem_ack) begin
          tag_we = 1'b1;
          data_we = 1'b1;
          data_wv = wr_q ? wdata_q : mem_rdata;
          st_d[idx] = wr_q ? ST_M : shared_q ? ST_S : ST_E;
          w_resp_d = wr_q ? 2'b01 : w_resp_q;
          r_resp_d = wr_q ? r_resp_q : 2'b01;
          rdata_d = wr_q ? rdata_q : mem_rdata;
          fsm_d = RESP;
        end
      end
      RESP: fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
    // snoops override own updates, except a completing fill which installs a new tag
    if (snp_shared && !(fill_done && sidx == idx)) st_d[sidx] = snp_nx;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm_q <= IDLE;
      st_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      shared_q <= 1'b0;
      rdata_q <= '0;
      w_resp_q <= 2'b00;
      r_resp_q <= 2'b00;
      w_hit_q <= 1'b0;
      r_hit_q <= 1'b0;
      snp_flush_q <= 1'b0;
      snp_data_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q <= st_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      shared_q <= shared_d;
      rdata_q <= rdata_d;
      w_resp_q <= w_resp_d;
      r_resp_q <= r_resp_d;
      w_hit_q <= w_hit_d;
      r_hit_q <= r_hit_d;
      snp_flush_q <= flush_now;
      if (flush_now) snp_data_q <= data_q[sidx];
    end
  end
  always_ff @(posedge clk) begin
    if (data_we) data_q[idx] <= data_wv;
    if (tag_we) tag_q[idx] <= tag;
  end
`ifdef MESI_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q <= '0;
    end else begin
      if (fsm_q == LOOKUP && hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (fsm_q == LOOKUP && !hit && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (fsm_q == WB && mem_ack && wb_cnt_q != '1) wb_cnt_q <= wb_cnt_q + 32'd1;
    end
  end
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt = wb_cnt_q;
`endif
endmodule
